// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and helpers for pipelined_addsub
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int ADDSUB_WIDTH = 64;

  // Clamp targets for the default datapath width.
  localparam logic [ADDSUB_WIDTH-1:0] SAT_MAX = {1'b0, {(ADDSUB_WIDTH-1){1'b1}}};
  localparam logic [ADDSUB_WIDTH-1:0] SAT_MIN = {1'b1, {(ADDSUB_WIDTH-1){1'b0}}};

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational SLICE_W-bit adder with carry-in, carry-out
// and the carry into its MSB
module adder_slice #(
  parameter int SLICE_W = 32
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb_in
);

  logic [SLICE_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  assign sum  = full[SLICE_W-1:0];
  assign cout = full[SLICE_W];

  // The MSB sum bit is a ^ b ^ carry-in, so the carry into it falls out directly.
  assign c_msb_in = full[SLICE_W-1] ^ a[SLICE_W-1] ^ b[SLICE_W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - valid/ready pipelined adder/subtractor with carry,
// overflow and zero flags; saturation enabled by PIPELINED_ADDSUB_SAT_EN
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDSUB_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef PIPELINED_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int SW = slice_width(WIDTH, STAGES);

  generate
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_addsub: STAGES must be 1..WIDTH and divide WIDTH");
    end
  endgenerate

  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            en;
  logic [STAGES-1:0]            vin;
  logic [STAGES-1:0][WIDTH-1:0] res_q, opa_q, opb_q;
  logic [STAGES-1:0][WIDTH-1:0] res_d, opa_d, opb_d;
  logic [STAGES-1:0]            cy_q, zr_q, sat_q;
  logic [STAGES-1:0]            cy_d, zr_d, sat_d;
  logic                         ov_q, ov_d;

  // A stage may load when it is empty or its contents move on this edge.
  always_comb begin
    en = '0;
    en[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      en[k] = !v_q[k] || en[k+1];
    end
  end

  assign in_ready = !reset && en[0];

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_in, b_in, r_in, r_out;
      logic             c_in, z_in, s_in;
      logic [SW-1:0]    s_sum;
      logic             s_cout, s_cmsb, ov_raw, clamp;
      logic             unused_stage;

      if (k == 0) begin : g_first
        assign a_in   = a;
        assign b_in   = b ^ {WIDTH{sub == OP_SUB}};
        assign c_in   = (sub == OP_SUB);
        assign r_in   = '0;
        assign z_in   = 1'b1;
        assign vin[k] = in_valid && in_ready;
`ifdef PIPELINED_ADDSUB_SAT_EN
        assign s_in   = sat;
`else
        assign s_in   = 1'b0;
`endif
      end else begin : g_next
        assign a_in   = opa_q[k-1];
        assign b_in   = opb_q[k-1];
        assign c_in   = cy_q[k-1];
        assign r_in   = res_q[k-1];
        assign z_in   = zr_q[k-1];
        assign s_in   = sat_q[k-1];
        assign vin[k] = v_q[k-1];
      end

      adder_slice #(.SLICE_W(SW)) u_slice (
        .a        (a_in[k*SW +: SW]),
        .b        (b_in[k*SW +: SW]),
        .cin      (c_in),
        .sum      (s_sum),
        .cout     (s_cout),
        .c_msb_in (s_cmsb)
      );

      assign ov_raw = s_cmsb ^ s_cout;

`ifdef PIPELINED_ADDSUB_SAT_EN
      assign clamp = (k == STAGES - 1) && s_in && ov_raw;
`else
      assign clamp = 1'b0;
`endif

      always_comb begin
        r_out = r_in;
        r_out[k*SW +: SW] = s_sum;
      end

      // Clamp direction follows the sign of the original operand a.
      assign res_d[k] = clamp ? {a_in[WIDTH-1], {(WIDTH-1){~a_in[WIDTH-1]}}} : r_out;
      assign zr_d[k]  = clamp ? 1'b0 : (z_in && (s_sum == '0));
      assign cy_d[k]  = s_cout;
      assign opa_d[k] = a_in;
      assign opb_d[k] = b_in;
      assign sat_d[k] = s_in;

      if (k == STAGES - 1) begin : g_last
        assign ov_d = ov_raw;
      end

      assign unused_stage = ov_raw ^ s_in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      res_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      cy_q  <= '0;
      zr_q  <= '0;
      sat_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          v_q[k] <= vin[k];
          if (vin[k]) begin
            res_q[k] <= res_d[k];
            opa_q[k] <= opa_d[k];
            opb_q[k] <= opb_d[k];
            cy_q[k]  <= cy_d[k];
            zr_q[k]  <= zr_d[k];
            sat_q[k] <= sat_d[k];
          end
        end
      end
      if (en[STAGES-1] && vin[STAGES-1]) begin
        ov_q <= ov_d;
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out       = res_q[STAGES-1];
  assign carry     = cy_q[STAGES-1];
  assign zero      = zr_q[STAGES-1];
  assign overflow  = ov_q;

  logic unused_regs;
  assign unused_regs = ^{opa_q[STAGES-1], opb_q[STAGES-1], sat_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - scoreboard bench for pipelined_addsub at STAGES 2, 1, 4 and 64
module tb_pipelined_addsub;

  localparam int W = 64;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         ov;
    logic         z;
    int           cyc;
    logic         lat;
  } exp_t;

  logic         clk;
  logic         reset, in_valid, sub, sat, out_ready;
  logic [W-1:0] a, b;
  logic [N-1:0] in_ready, out_valid, carry, overflow, zero;
  logic [W-1:0] out_v [N];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic lat_mode = 1'b0;
  int   pending [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: plain two's-complement arithmetic, flags from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic st);
    exp_t e;
    logic [W:0] f;
    if (s) begin
      e.res = x - y;
      e.c   = (x >= y);
      e.ov  = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
    end else begin
      f     = {1'b0, x} + {1'b0, y};
      e.res = f[W-1:0];
      e.c   = f[W];
      e.ov  = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
    end
    e.z = (e.res == '0);
    if (st && e.ov) begin
      e.res = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      e.z   = 1'b0;
    end
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 64;
    exp_t q[$];

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .a         (a),
      .b         (b),
      .sub       (sub),
`ifdef PIPELINED_ADDSUB_SAT_EN
      .sat       (sat),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out       (out_v[g]),
      .carry     (carry[g]),
      .overflow  (overflow[g]),
      .zero      (zero[g])
    );

    always @(negedge clk) begin
      exp_t e;
      if (reset) begin
        q.delete();
        chk($sformatf("s%0d_in_ready_in_reset", S), W'(in_ready[g]), W'(0));
      end else begin
        if (q.size() == 0) begin
          chk($sformatf("s%0d_spurious_out_valid", S), W'(out_valid[g]), W'(0));
        end else if (out_valid[g]) begin
          e = q[0];
          chk($sformatf("s%0d_out", S), out_v[g], e.res);
          chk($sformatf("s%0d_carry", S), W'(carry[g]), W'(e.c));
          chk($sformatf("s%0d_overflow", S), W'(overflow[g]), W'(e.ov));
          chk($sformatf("s%0d_zero", S), W'(zero[g]), W'(e.z));
          if (e.lat) chk($sformatf("s%0d_latency", S), W'(cyc - e.cyc), W'(S));
          if (out_ready) void'(q.pop_front());
        end
        if (lat_mode) chk($sformatf("s%0d_full_rate_in_ready", S), W'(in_ready[g]), W'(1));
        if (in_valid && in_ready[g]) begin
          e = model(a, b, sub, sat);
          e.cyc = cyc;
          e.lat = lat_mode;
          q.push_back(e);
        end
      end
      pending[g] = q.size();
    end
  end

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(W-1){1'b1}}};
      3:       v = {1'b1, {(W-1){1'b0}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic set_rand();
    a   = rnd();
    b   = rnd();
    sub = 1'($urandom_range(0, 1));
`ifdef PIPELINED_ADDSUB_SAT_EN
    sat = 1'($urandom_range(0, 1));
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 after the primary DUT accepted.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic st);
    int n = 0;
    a = x; b = y; sub = s; sat = st; in_valid = 1'b1;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!in_ready[0] && n < 200);
    if (!in_ready[0]) chk("send_in_ready", W'(in_ready[0]), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((pending[0] + pending[1] + pending[2] + pending[3]) != 0 && n < 2000);
    chk("drain_empty", W'(pending[0] + pending[1] + pending[2] + pending[3]), W'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int sent;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
    for (int g = 0; g < N; g++) pending[g] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk($sformatf("rst_out_valid_%0d", g), W'(out_valid[g]), W'(0));
      chk($sformatf("rst_out_%0d", g), out_v[g], W'(0));
      chk($sformatf("rst_flags_%0d", g), W'({carry[g], overflow[g], zero[g]}), W'(0));
      chk($sformatf("rst_in_ready_%0d", g), W'(in_ready[g]), W'(1));
    end
    @(posedge clk); #1;

    // Directed corner cases, latency-checked.
    lat_mode = 1'b1;
    send(64'd5, 64'd7, 1'b0, 1'b0);
    send(64'd3, 64'd5, 1'b1, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    send(64'd7, 64'd7, 1'b1, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
`ifdef PIPELINED_ADDSUB_SAT_EN
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
`endif
    drain();
    lat_mode = 1'b0;

    // Backpressure: four ops, out_ready low in cycles 3-6.
    sent = 0;
    for (int c = 1; c <= 24; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 4);
      if (sent < 4 && (c == 1 || in_valid == 1'b1)) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'(c & 1);
      end
      @(negedge clk); #1;
      if (c == 5) begin
        chk("bp_in_ready_full", W'(in_ready[0]), W'(0));
        chk("bp_out_valid_held", W'(out_valid[0]), W'(1));
      end
      if (in_valid && in_ready[0]) sent++;
      @(posedge clk); #1;
    end
    chk("bp_all_sent", W'(sent), W'(4));
    drain();

    // Full-rate random stream.
    lat_mode  = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      set_rand();
      @(posedge clk); #1;
    end
    drain();
    lat_mode = 1'b0;

    // Random valid/ready traffic.
    for (int i = 0; i < 800; i++) begin
      set_rand();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    drain();

    // Reset with operations in flight.
    in_valid = 1'b1;
    set_rand();
    @(posedge clk); #1;
    set_rand();
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk($sformatf("midrst_out_valid_%0d", g), W'(out_valid[g]), W'(0));
      chk($sformatf("midrst_flags_%0d", g), W'({carry[g], overflow[g], zero[g]}), W'(0));
    end
    @(posedge clk); #1;
    repeat (100) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
